// File: rtl/wbu_arb.sv
// Write-back arbiter: merges ALU, MUL and DIV results onto one register-file
// write port and one commit-notification port. ALU has priority, with an
// anti-starvation override for MUL and DIV and round-robin between them.
// The output is registered, so a result appears one cycle after its handshake.

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

module wbu_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid_i,
  input  logic                        mul_valid_i,
  input  logic                        div_valid_i,
  input  logic [`REG_DATA_WIDTH-1:0]  alu_wdata_i,
  input  logic [`REG_DATA_WIDTH-1:0]  mul_wdata_i,
  input  logic [`REG_DATA_WIDTH-1:0]  div_wdata_i,
  input  logic [`REG_ADDR_WIDTH-1:0]  alu_waddr_i,
  input  logic [`REG_ADDR_WIDTH-1:0]  mul_waddr_i,
  input  logic [`REG_ADDR_WIDTH-1:0]  div_waddr_i,
  input  logic [`COMMIT_ID_WIDTH-1:0] alu_commit_id_i,
  input  logic [`COMMIT_ID_WIDTH-1:0] mul_commit_id_i,
  input  logic [`COMMIT_ID_WIDTH-1:0] div_commit_id_i,
  output logic                        alu_ready_o,
  output logic                        mul_ready_o,
  output logic                        div_ready_o,
  output logic                        reg_we_o,
  output logic [`REG_ADDR_WIDTH-1:0]  reg_waddr_o,
  output logic [`REG_DATA_WIDTH-1:0]  reg_wdata_o,
  output logic                        commit_valid_o,
  output logic [`COMMIT_ID_WIDTH-1:0] commit_id_o
);

  localparam int               CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_MUL, GNT_DIV} gnt_e;

  gnt_e                        gnt;
  logic                        mul_starved, div_starved;
  logic [CNT_W-1:0]            cnt_mul_q, cnt_mul_d, cnt_div_q, cnt_div_d;
  logic                        rr_q, rr_d;
  logic [`REG_ADDR_WIDTH-1:0]  sel_waddr;
  logic [`REG_DATA_WIDTH-1:0]  sel_wdata;
  logic [`COMMIT_ID_WIDTH-1:0] sel_id;
  logic                        reg_we_q, reg_we_d;
  logic                        commit_valid_q, commit_valid_d;
  logic [`REG_ADDR_WIDTH-1:0]  reg_waddr_q, reg_waddr_d;
  logic [`REG_DATA_WIDTH-1:0]  reg_wdata_q, reg_wdata_d;
  logic [`COMMIT_ID_WIDTH-1:0] commit_id_q, commit_id_d;

  assign mul_starved = mul_valid_i && (cnt_mul_q == LIMIT);
  assign div_starved = div_valid_i && (cnt_div_q == LIMIT);

  // Grant selection: starved source first, then ALU, then MUL/DIV round-robin.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    gnt = GNT_NONE;
    if (!rst_n)                                gnt = GNT_NONE;
    else if (mul_starved && div_starved)       gnt = rr_q ? GNT_DIV : GNT_MUL;
    else if (mul_starved)                      gnt = GNT_MUL;
    else if (div_starved)                      gnt = GNT_DIV;
    else if (alu_valid_i)                      gnt = GNT_ALU;
    else if (mul_valid_i && div_valid_i)       gnt = rr_q ? GNT_DIV : GNT_MUL;
    else if (mul_valid_i)                      gnt = GNT_MUL;
    else if (div_valid_i)                      gnt = GNT_DIV;
  end

  assign alu_ready_o = (gnt == GNT_ALU);
  assign mul_ready_o = (gnt == GNT_MUL);
  assign div_ready_o = (gnt == GNT_DIV);

  // Starvation counters and round-robin pointer update.
  always_comb begin
    cnt_mul_d = '0;
    cnt_div_d = '0;
    rr_d      = rr_q;
    if (mul_valid_i && gnt != GNT_MUL)
      cnt_mul_d = (cnt_mul_q == LIMIT) ? LIMIT : cnt_mul_q + CNT_W'(1);
    if (div_valid_i && gnt != GNT_DIV)
      cnt_div_d = (cnt_div_q == LIMIT) ? LIMIT : cnt_div_q + CNT_W'(1);
    if (gnt == GNT_MUL) rr_d = 1'b1;
    if (gnt == GNT_DIV) rr_d = 1'b0;
  end

  // Payload mux and output-stage next values; data holds when nothing is granted.
  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    sel_id    = '0;
    case (gnt)
      GNT_ALU: begin sel_waddr = alu_waddr_i; sel_wdata = alu_wdata_i; sel_id = alu_commit_id_i; end
      GNT_MUL: begin sel_waddr = mul_waddr_i; sel_wdata = mul_wdata_i; sel_id = mul_commit_id_i; end
      GNT_DIV: begin sel_waddr = div_waddr_i; sel_wdata = div_wdata_i; sel_id = div_commit_id_i; end
      default: ;
    endcase
    commit_valid_d = (gnt != GNT_NONE);
    reg_we_d       = (gnt != GNT_NONE) && (sel_waddr != '0);
    reg_waddr_d    = (gnt != GNT_NONE) ? sel_waddr : reg_waddr_q;
    reg_wdata_d    = (gnt != GNT_NONE) ? sel_wdata : reg_wdata_q;
    commit_id_d    = (gnt != GNT_NONE) ? sel_id    : commit_id_q;
  end

  // State registers; reset clears arbitration state and discards the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_mul_q      <= '0;
      cnt_div_q      <= '0;
      rr_q           <= 1'b0;
      reg_we_q       <= 1'b0;
      commit_valid_q <= 1'b0;
      reg_waddr_q    <= '0;
      reg_wdata_q    <= '0;
      commit_id_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cnt_mul_q      <= cnt_mul_d;
      cnt_div_q      <= cnt_div_d;
      rr_q           <= rr_d;
      reg_we_q       <= reg_we_d;
      commit_valid_q <= commit_valid_d;
      reg_waddr_q    <= reg_waddr_d;
      reg_wdata_q    <= reg_wdata_d;
      commit_id_q    <= commit_id_d;
    end
  end

  assign reg_we_o       = reg_we_q;
  assign commit_valid_o = commit_valid_q;
  assign reg_waddr_o    = reg_waddr_q;
  assign reg_wdata_o    = reg_wdata_q;
  assign commit_id_o    = commit_id_q;

endmodule

// File: tb/tb_wbu_arb.sv
// Self-checking bench for wbu_arb: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

module tb_wbu_arb;
  localparam int DW    = `REG_DATA_WIDTH;
  localparam int AW    = `REG_ADDR_WIDTH;
  localparam int IW    = `COMMIT_ID_WIDTH;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    v = '0;            // {div, mul, alu}
  logic [DW-1:0] wdata [3];
  logic [AW-1:0] waddr [3];
  logic [IW-1:0] cid   [3];
  logic          alu_ready, mul_ready, div_ready, reg_we, commit_valid;
  logic [AW-1:0] reg_waddr;
  logic [DW-1:0] reg_wdata;
  logic [IW-1:0] commit_id;
  logic [2:0]    rdy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign rdy = {div_ready, mul_ready, alu_ready};

  wbu_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(v[0]), .mul_valid_i(v[1]), .div_valid_i(v[2]),
    .alu_wdata_i(wdata[0]), .mul_wdata_i(wdata[1]), .div_wdata_i(wdata[2]),
    .alu_waddr_i(waddr[0]), .mul_waddr_i(waddr[1]), .div_waddr_i(waddr[2]),
    .alu_commit_id_i(cid[0]), .mul_commit_id_i(cid[1]), .div_commit_id_i(cid[2]),
    .alu_ready_o(alu_ready), .mul_ready_o(mul_ready), .div_ready_o(div_ready),
    .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata),
    .commit_valid_o(commit_valid), .commit_id_o(commit_id)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Waiting-cycle counts per slow source, round-robin preference, and the
  // result that should be visible on the output port.
  int            w_mul, w_div;
  bit            prefer_div;
  bit            e_we, e_cv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [IW-1:0] e_id;

  task automatic model_reset();
    w_mul = 0; w_div = 0; prefer_div = 0;
    e_we = 0; e_cv = 0; e_addr = '0; e_data = '0; e_id = '0;
  endtask

  // Returns granted source index (0 alu, 1 mul, 2 div) or -1.
  function automatic int model_grant(logic [2:0] vv);
    bit sm = vv[1] && (w_mul >= LIMIT);
    bit sd = vv[2] && (w_div >= LIMIT);
    if (sm && sd) return prefer_div ? 2 : 1;
    if (sm) return 1;
    if (sd) return 2;
    if (vv[0]) return 0;
    if (vv[1] && vv[2]) return prefer_div ? 2 : 1;
    if (vv[1]) return 1;
    if (vv[2]) return 2;
    return -1;
  endfunction

  function automatic logic [2:0] onehot(int g);
    logic [2:0] r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_step(int g, logic [2:0] vv);
    w_mul = (g == 1 || !vv[1]) ? 0 : (w_mul < LIMIT ? w_mul + 1 : LIMIT);
    w_div = (g == 2 || !vv[2]) ? 0 : (w_div < LIMIT ? w_div + 1 : LIMIT);
    if (g == 1) prefer_div = 1;
    if (g == 2) prefer_div = 0;
    if (g >= 0) begin
      e_cv = 1; e_we = (waddr[g] != 0);
      e_addr = waddr[g]; e_data = wdata[g]; e_id = cid[g];
    end else begin
      e_cv = 0; e_we = 0;
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, ".we"},    64'(reg_we),       64'(e_we));
    check({tag, ".cv"},    64'(commit_valid), 64'(e_cv));
    check({tag, ".waddr"}, 64'(reg_waddr),    64'(e_addr));
    check({tag, ".wdata"}, 64'(reg_wdata),    64'(e_data));
    check({tag, ".id"},    64'(commit_id),    64'(e_id));
  endtask

  // One clock cycle starting from a negedge with inputs already driven.
  task automatic cycle(input string tag, output int g, output logic [2:0] got);
    #1;
    g = model_grant(v);
    got = rdy;
    check({tag, ".ready"}, 64'(rdy), 64'(onehot(g)));
    @(posedge clk);
    model_step(g, v);
    #1 check_out(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    v = 3'b111;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset.ready", 64'(rdy), 64'd0);
    check_out("reset");
    @(negedge clk);
    v = '0;
    rst_n = 1'b1;
  endtask

  task automatic set_src(int s, logic [AW-1:0] a, logic [DW-1:0] d, logic [IW-1:0] i);
    waddr[s] = a; wdata[s] = d; cid[s] = i;
  endtask

  // ---------------- directed vector table ----------------
  // Source s is given (addr, data+s, id+s), so rows name the base values.
  typedef struct {
    logic [2:0]    v;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [2:0]    exp_rdy;
    logic          exp_we;
    logic [DW-1:0] exp_data;
    logic [IW-1:0] exp_id;
  } vec_t;

  vec_t vecs [7];
  int        g;
  logic [2:0] got;
  bit [2:0]  pend;

  initial begin
    for (int s = 0; s < 3; s++) set_src(s, '0, '0, '0);
    vecs[0] = '{3'b010, 5,  32'h12345677, 2, 3'b010, 1, 32'h12345678, 3};  // lone MUL
    vecs[1] = '{3'b001, 3,  32'hAAAA0000, 1, 3'b001, 1, 32'hAAAA0000, 1};  // lone ALU
    vecs[2] = '{3'b100, 0,  32'h00000055, 5, 3'b100, 0, 32'h00000057, 7};  // DIV to x0
    vecs[3] = '{3'b011, 10, 32'd100,      0, 3'b001, 1, 32'd100,      0};  // ALU beats MUL
    vecs[4] = '{3'b110, 31, 32'd200,      4, 3'b010, 1, 32'd201,      5};  // rr starts at MUL
    vecs[5] = '{3'b111, 7,  32'd300,      8, 3'b001, 1, 32'd300,      8};  // all valid
    vecs[6] = '{3'b000, 9,  32'd400,      1, 3'b000, 0, 32'd0,        0};  // idle

    for (int k = 0; k < 7; k++) begin
      do_reset();
      for (int s = 0; s < 3; s++)
        set_src(s, vecs[k].addr, vecs[k].data + DW'(s), vecs[k].id + IW'(s));
      v = vecs[k].v;
      #1 check($sformatf("vec%0d.ready", k), 64'(rdy), 64'(vecs[k].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.we", k), 64'(reg_we), 64'(vecs[k].exp_we));
      check($sformatf("vec%0d.cv", k), 64'(commit_valid), 64'(vecs[k].exp_rdy != 0));
      if (vecs[k].exp_rdy != 0) begin
        check($sformatf("vec%0d.waddr", k), 64'(reg_waddr), 64'(vecs[k].addr));
        check($sformatf("vec%0d.wdata", k), 64'(reg_wdata), 64'(vecs[k].exp_data));
        check($sformatf("vec%0d.id", k),    64'(commit_id), 64'(vecs[k].exp_id));
      end
    end

    // ALU and MUL together, then ALU drops: MUL follows on the next cycle.
    do_reset();
    set_src(0, 1, 32'h11, 1); set_src(1, 2, 32'h22, 2); set_src(2, 3, 32'h33, 3);
    v = 3'b011; cycle("alu_then_mul0", g, got); check("alu_then_mul0.g", 64'(got), 64'(3'b001));
    v = 3'b010; cycle("alu_then_mul1", g, got); check("alu_then_mul1.g", 64'(got), 64'(3'b010));

    // ALU continuously valid: MUL overrides after LIMIT waiting cycles, then ALU resumes.
    do_reset();
    v = 3'b011;
    for (int c = 0; c < LIMIT; c++) begin
      cycle("starve_wait", g, got); check("starve_wait.g", 64'(got), 64'(3'b001));
    end
    cycle("starve_hit", g, got); check("starve_hit.g", 64'(got), 64'(3'b010));
    v = 3'b001;
    cycle("starve_resume", g, got); check("starve_resume.g", 64'(got), 64'(3'b001));

    // MUL/DIV contention alternates starting with MUL.
    do_reset();
    v = 3'b110;
    for (int c = 0; c < 4; c++) begin
      cycle("alternate", g, got);
      check($sformatf("alternate%0d.g", c), 64'(got), (c % 2 == 0) ? 64'(3'b010) : 64'(3'b100));
    end

    // Stall hold: MUL denied 3 cycles with payload held, written back exactly once.
    do_reset();
    set_src(1, 12, 32'hDEADBEEF, 9);
    v = 3'b011;
    for (int c = 0; c < 3; c++) cycle("stall_deny", g, got);
    v = 3'b010;
    cycle("stall_grant", g, got);
    check("stall.wdata", 64'(reg_wdata), 64'(32'hDEADBEEF));
    check("stall.id",    64'(commit_id), 64'd9);
    check("stall.cv",    64'(commit_valid), 64'd1);
    v = 3'b000;
    cycle("stall_after", g, got);
    check("stall.no_dup", 64'(commit_valid), 64'd0);

    // Reset mid-stream: output entry discarded, arbitration state cleared.
    do_reset();
    set_src(1, 4, 32'h44, 4); set_src(2, 6, 32'h66, 6);
    v = 3'b110;
    #1 check("midrst.ready", 64'(rdy), 64'(3'b010));
    @(posedge clk);
    model_step(1, v);
    #1 check("midrst.cv_before", 64'(commit_valid), 64'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst.cv",    64'(commit_valid), 64'd0);
    check("midrst.we",    64'(reg_we), 64'd0);
    check("midrst.ready_low", 64'(rdy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst.cnt_mul", 64'(dut.cnt_mul_q), 64'd0);
    check("midrst.cnt_div", 64'(dut.cnt_div_q), 64'd0);
    check("midrst.rr",      64'(dut.rr_q), 64'd0);
    cycle("post_reset", g, got);
    check("post_reset.g", 64'(got), 64'(3'b010));
    check("post_reset.cv", 64'(commit_valid), 64'd1);

    // Randomized traffic: each source holds its payload until granted.
    do_reset();
    pend = '0;
    for (int n = 0; n < 600; n++) begin
      for (int s = 0; s < 3; s++) begin
        if (!pend[s] && $urandom_range(0, 99) < ((s == 0) ? 70 : 45)) begin
          pend[s] = 1'b1;
          set_src(s, ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom),
                  DW'($urandom), IW'($urandom));
        end
      end
      v = pend;
      cycle("rand", g, got);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wbu_arb.md
WBU_ARB -- requirements
Module: wbu_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive waiting cycles (1..15) after which a MUL or DIV request overrides ALU priority.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports alu_valid_i/mul_valid_i/div_valid_i  input  1 each  source has a result to write back.
REQ-005 SHALL have ports alu_/mul_/div_ wdata_i  input  `REG_DATA_WIDTH each  result data.
REQ-006 SHALL have ports alu_/mul_/div_ waddr_i  input  `REG_ADDR_WIDTH each  destination register.
REQ-007 SHALL have ports alu_/mul_/div_ commit_id_i  input  `COMMIT_ID_WIDTH each  commit tag.
REQ-008 SHALL have ports alu_ready_o/mul_ready_o/div_ready_o  output  1 each  result accepted this cycle; mul_ready_o drives the multiplier's wb_ready.
REQ-009 SHALL have port reg_we_o  output  1  register-file write enable.
REQ-010 SHALL have ports reg_waddr_o  output  `REG_ADDR_WIDTH, reg_wdata_o  output  `REG_DATA_WIDTH  register-file write port.
REQ-011 SHALL have ports commit_valid_o  output  1, commit_id_o  output  `COMMIT_ID_WIDTH  retire notification.

Function
REQ-012 SHALL accept a source's result when valid_i & ready_o are both high on a rising edge (a handshake); sources hold their payload stable while valid_i & !ready_o.
REQ-013 SHALL raise at most one ready_o per cycle and SHALL hold ready_o low for a source whose valid_i is low.
REQ-014 SHALL compute ready_o combinationally from the current valid_i inputs and internal state, with no dependency on the payload inputs.
REQ-015 SHALL keep two counters, cnt_mul and cnt_div: each increments per cycle its source is valid but not granted, saturates at STARVE_LIMIT, and clears on that source's grant or when its valid is low.
REQ-016 SHALL keep a round-robin bit rr (0 = prefer MUL, 1 = prefer DIV): set to 1 after a MUL grant, cleared to 0 after a DIV grant, unchanged on an ALU grant or when idle.
REQ-017 SHALL grant in this order:
- (a) a valid source whose counter equals STARVE_LIMIT; if both MUL and DIV qualify, rr decides;
- (b) otherwise ALU if valid;
- (c) otherwise MUL/DIV, the single valid one or the rr-preferred one when both are valid.
REQ-018 SHALL register the granted payload into an output stage one cycle after the handshake; there is no backpressure from the register file.
REQ-019 SHALL drive reg_we_o high for exactly one cycle per accepted result whose waddr is nonzero; a waddr of 0 SHALL give reg_we_o=0.
REQ-020 SHALL drive commit_valid_o high for exactly one cycle per accepted result, including waddr=0 writes.
REQ-021 SHALL drive commit_valid_o=0 and reg_we_o=0 in any cycle following a cycle with no grant, holding the last payload values on the data outputs.
REQ-022 SHALL sustain one grant per cycle (full throughput) with no bubbles while any valid_i is high.

Reset
REQ-023 SHALL, while rst_n is low, force reg_we_o=0, commit_valid_o=0, reg_waddr_o=0, reg_wdata_o=0, commit_id_o=0, cnt_mul=0, cnt_div=0 and rr=0.
REQ-024 SHALL hold all ready_o low while rst_n is low.
REQ-025 SHALL discard an in-flight output-stage entry on reset assertion mid-operation.
REQ-026 SHALL allow the first grant on the first rising edge after rst_n deasserts.

Verification
REQ-027 Lone MUL: mul_valid_i=1, waddr=5, wdata=0x12345678, id=3 -> mul_ready_o=1 the same cycle; next cycle reg_we_o=1, reg_waddr_o=5, reg_wdata_o=0x12345678, commit_valid_o=1, commit_id_o=3.
REQ-028 ALU vs MUL: both valid on cycle 0 -> ALU granted on cycle 0 and MUL on cycle 1; with ALU continuously valid, MUL is granted on cycle STARVE_LIMIT=4 (after 4 waiting cycles), then ALU resumes.
REQ-029 MUL/DIV contention: both held valid with ALU idle after reset -> grants alternate MUL, DIV, MUL, DIV, one per cycle.
REQ-030 x0 write: DIV result with waddr=0, id=7 -> div_ready_o=1; next cycle reg_we_o=0, commit_valid_o=1, commit_id_o=7.
REQ-031 Reset mid-stream: MUL granted, then rst_n pulled low before the next edge -> commit_valid_o=0 and reg_we_o=0 immediately; cnt_mul=cnt_div=0 and rr=0 after release.
REQ-032 Stall hold: MUL valid and denied for 3 cycles with payload held -> the payload written back equals the held values; no duplicate commit_id_o.
